// File: rtl/pif_bus_pkg.sv
// Shared definitions for the PIF 6502 bus controller and its address decoder:
// memory-map region bases, region-select type, local address widths and
// the controller FSM state codes.
package pif_bus_pkg;

  localparam int unsigned CPU_AW = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RAM_AW = 13;
  localparam int unsigned ROM_AW = 12;
  localparam int unsigned OFS_W  = 13;
  localparam int unsigned CNT_W  = 8;

  // Region bases; each region runs up to the next base (ROM up to 0xFFFF).
  localparam logic [CPU_AW-1:0] RAM_BASE = 16'h0000;
  localparam logic [CPU_AW-1:0] IO_BASE  = 16'h2000;
  localparam logic [CPU_AW-1:0] ROM_BASE = 16'hC000;

  // Read data returned by an I/O read that timed out.
  localparam logic [DATA_W-1:0] RDATA_TIMEOUT = 8'hFF;

  typedef enum logic [1:0] {
    REGION_RAM = 2'd0,
    REGION_IO  = 2'd1,
    REGION_ROM = 2'd2
  } region_e;

  // Controller FSM states.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ROM_WAIT = 3'd1;
  localparam logic [2:0] ST_RAM_WAIT = 3'd2;
  localparam logic [2:0] ST_IO_WAIT  = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;

endpackage

// File: rtl/pif_bus_ctrl_decode.sv
// pif_addr_decode: combinational decode of a 16-bit CPU address into a
// region select and a region-local offset. Shared with the debug bus.
//   addr      in  16  CPU byte address
//   region_c  out     RAM / IO / ROM select
//   offset_c  out 13  local offset (RAM: addr[12:0]; ROM: 4 KB mirrored offset;
//                     IO: addr - IO_BASE, truncated)
module pif_addr_decode
  import pif_bus_pkg::*;
(
  input  logic [CPU_AW-1:0] addr,
  output region_e           region_c,
  output logic [OFS_W-1:0]  offset_c
);

  // Highest matching base wins; ROM offset is folded to 12 bits so the
  // 16 KB window sees four copies of the 4 KB ROM.
  always_comb begin
    region_c = REGION_RAM;
    offset_c = OFS_W'(addr - RAM_BASE);
    if (addr >= ROM_BASE) begin
      region_c = REGION_ROM;
      offset_c = OFS_W'(ROM_AW'(addr - ROM_BASE));
    end else if (addr >= IO_BASE) begin
      region_c = REGION_IO;
      offset_c = OFS_W'(addr - IO_BASE);
    end
  end

endmodule

// File: rtl/pif_bus_ctrl.sv
// pif_bus_ctrl: bus controller between the PIF 6502 core and boot ROM,
// work RAM and the I/O window. One acknowledge per CPU request.
//   clk, reset_n            clock, async active-low reset
//   cpu_req/we/addr/wdata   CPU request (held until cpu_ack)
//   cpu_ack/rdata, bus_err  completion pulse, read data, sticky I/O timeout
//   rom_address/oe, rom_valid/q   rom_6502 read port
//   ram_address/oe/we/wdata, ram_valid/q   work RAM port
//   io_req/we/addr/wdata, io_ack/rdata     I/O handshake port
// All outputs are registered.
module pif_bus_ctrl
  import pif_bus_pkg::*;
#(
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [CPU_AW-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              bus_err,
  output logic [ROM_AW-1:0] rom_address,
  output logic              rom_oe,
  input  logic              rom_valid,
  input  logic [DATA_W-1:0] rom_q,
  output logic [RAM_AW-1:0] ram_address,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_valid,
  input  logic [DATA_W-1:0] ram_q,
  output logic              io_req,
  output logic              io_we,
  output logic [CPU_AW-1:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic              io_ack,
  input  logic [DATA_W-1:0] io_rdata
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(IO_TIMEOUT);

  region_e           region_c;
  logic [OFS_W-1:0]  offset_c;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  io_cnt_q, io_cnt_d;

  logic              cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_d;
  logic              bus_err_d;
  logic [ROM_AW-1:0] rom_address_d;
  logic              rom_oe_d;
  logic [RAM_AW-1:0] ram_address_d;
  logic              ram_oe_d;
  logic              ram_we_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic              io_req_d;
  logic              io_we_d;
  logic [CPU_AW-1:0] io_addr_d;
  logic [DATA_W-1:0] io_wdata_d;

  pif_addr_decode u_decode (
    .addr     (cpu_addr),
    .region_c (region_c),
    .offset_c (offset_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      io_cnt_q    <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      bus_err     <= 1'b0;
      rom_address <= '0;
      rom_oe      <= 1'b0;
      ram_address <= '0;
      ram_oe      <= 1'b0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      io_req      <= 1'b0;
      io_we       <= 1'b0;
      io_addr     <= '0;
      io_wdata    <= '0;
    end else begin
      state_q     <= state_d;
      io_cnt_q    <= io_cnt_d;
      cpu_ack     <= cpu_ack_d;
      cpu_rdata   <= cpu_rdata_d;
      bus_err     <= bus_err_d;
      rom_address <= rom_address_d;
      rom_oe      <= rom_oe_d;
      ram_address <= ram_address_d;
      ram_oe      <= ram_oe_d;
      ram_we      <= ram_we_d;
      ram_wdata   <= ram_wdata_d;
      io_req      <= io_req_d;
      io_we       <= io_we_d;
      io_addr     <= io_addr_d;
      io_wdata    <= io_wdata_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    state_d       = state_q;
    io_cnt_d      = io_cnt_q;
    cpu_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata;
    bus_err_d     = bus_err;
    rom_address_d = rom_address;
    rom_oe_d      = 1'b0;
    ram_address_d = ram_address;
    ram_oe_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_wdata_d   = ram_wdata;
    io_req_d      = io_req;
    io_we_d       = io_we;
    io_addr_d     = io_addr;
    io_wdata_d    = io_wdata;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !cpu_ack) begin
          case (region_c)
            REGION_ROM: begin
              // ROM writes are dropped silently and acked like a RAM write.
              if (cpu_we) begin
                state_d = ST_ACK;
              end else begin
                rom_oe_d      = 1'b1;
                rom_address_d = offset_c[ROM_AW-1:0];
                state_d       = ST_ROM_WAIT;
              end
            end
            REGION_RAM: begin
              ram_address_d = offset_c[RAM_AW-1:0];
              if (cpu_we) begin
                ram_we_d    = 1'b1;
                ram_wdata_d = cpu_wdata;
                state_d     = ST_ACK;
              end else begin
                ram_oe_d = 1'b1;
                state_d  = ST_RAM_WAIT;
              end
            end
            default: begin
              io_req_d   = 1'b1;
              io_we_d    = cpu_we;
              io_addr_d  = cpu_addr;
              io_wdata_d = cpu_wdata;
              io_cnt_d   = '0;
              state_d    = ST_IO_WAIT;
            end
          endcase
        end
      end

      ST_ROM_WAIT: begin
        if (rom_valid) begin
          cpu_rdata_d = rom_q;
          cpu_ack_d   = 1'b1;
          state_d     = ST_ACK;
        end
      end

      ST_RAM_WAIT: begin
        if (ram_valid) begin
          cpu_rdata_d = ram_q;
          cpu_ack_d   = 1'b1;
          state_d     = ST_ACK;
        end
      end

      // io_ack is checked first so it wins over a simultaneous timeout.
      ST_IO_WAIT: begin
        if (io_ack) begin
          io_req_d  = 1'b0;
          cpu_ack_d = 1'b1;
          state_d   = ST_ACK;
          if (!io_we) begin
            cpu_rdata_d = io_rdata;
          end
        end else if (io_cnt_q >= TIMEOUT_CNT) begin
          io_req_d  = 1'b0;
          bus_err_d = 1'b1;
          cpu_ack_d = 1'b1;
          state_d   = ST_ACK;
          if (!io_we) begin
            cpu_rdata_d = RDATA_TIMEOUT;
          end
        end else if (io_cnt_q != '1) begin
          io_cnt_d = io_cnt_q + CNT_W'(1);
        end
      end

      // Reads/IO raise cpu_ack on entry; writes enter with it low and
      // raise it here, one cycle later. Either way it lasts one cycle.
      ST_ACK: begin
        if (cpu_ack) begin
          state_d = ST_IDLE;
        end else begin
          cpu_ack_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
